spi_engine: RTL and testbench

SPI_ENGINE -- requirements
Module: spi_engine

---
 rtl/spi_engine.sv | 196 +++++++++++++++++++
 tb/tb_spi_engine.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_engine.sv
// rtl/spi_engine.sv - single-byte mode-0 SPI master with two slave selects
//
// Purpose: shifts one byte out on MOSI (MSB first) while shifting one byte in
// from the selected MISO line. SCK idles low. Each half-period lasts 2^DIV
// clock cycles.
//
// Ports:
//   CLKx4   in   sole clock, rising edge
//   nRESET  in   asynchronous active-low reset
//   WR      in   transfer-start strobe (WDATA, SSEL, DIV sampled with it)
//   WDATA   in   [7:0] byte to transmit
//   SSEL    in   [1:0] active-low slave selects to apply
//   DIV     in   [1:0] half-period select
//   RELEASE in   strobe that returns both selects high
//   MISO    in   [2:0] serial in: slave 0, slave 1, default device
//   SCK     out  serial clock
//   MOSI    out  serial data out
//   nSS     out  [1:0] registered active-low selects
//   RDATA   out  [7:0] last received byte
//   BUSY    out  transfer in progress
//   DONE    out  one-cycle end-of-transfer pulse
//   OVR     out  sticky: a WR arrived while busy and was dropped

module spi_engine (
  input  logic       CLKx4,
  input  logic       nRESET,
  input  logic       WR,
  input  logic [7:0] WDATA,
  input  logic [1:0] SSEL,
  input  logic [1:0] DIV,
  input  logic       RELEASE,
  input  logic [2:0] MISO,
  output logic       SCK,
  output logic       MOSI,
  output logic [1:0] nSS,
  output logic [7:0] RDATA,
  output logic       BUSY,
  output logic       DONE,
  output logic       OVR
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  state_t     state_q;
  state_t     state_d;

  logic [7:0] tx_sr;
  logic [7:0] rx_sr;
  logic [2:0] bitcnt;
  logic [2:0] hcnt;
  logic [2:0] half_max;   // H-1, latched from DIV at transfer start
  logic       rel_pend;

  logic       tick;
  logic       do_start;
  logic       do_rise;
  logic       do_fall;
  logic       do_finish;
  logic       miso_sel;

  // The half-period counter runs from 0 to H-1; tick marks the last cycle.
  assign tick = (hcnt == half_max);

  // Slave routing follows the selects latched at transfer start, so SSEL
  // wiggling mid-transfer cannot redirect the receive path.
  always_comb begin
    miso_sel = 1'b0;
    case (nSS)
      2'b10:   miso_sel = MISO[0];
      2'b01:   miso_sel = MISO[1];
      2'b11:   miso_sel = MISO[2];
      default: miso_sel = MISO[0] | MISO[1];
    endcase
  end

  always_ff @(posedge CLKx4 or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    do_start  = 1'b0;
    do_rise   = 1'b0;
    do_fall   = 1'b0;
    do_finish = 1'b0;
    case (state_q)
      IDLE: begin
        if (WR) begin
          do_start = 1'b1;
          state_d  = LOW;
        end
      end
      LOW: begin
        if (tick) begin
          do_rise = 1'b1;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (tick) begin
          if (bitcnt == 3'd7) begin
            do_finish = 1'b1;
            state_d   = IDLE;
          end else begin
            do_fall = 1'b1;
            state_d = LOW;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLKx4 or negedge nRESET) begin
    if (!nRESET) begin
      tx_sr    <= 8'h00;
      rx_sr    <= 8'h00;
      bitcnt   <= 3'd0;
      hcnt     <= 3'd0;
      half_max <= 3'd0;
      rel_pend <= 1'b0;
      SCK      <= 1'b0;
      MOSI     <= 1'b0;
      nSS      <= 2'b11;
      RDATA    <= 8'h00;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      OVR      <= 1'b0;
    end else begin
      DONE <= 1'b0;

      if (do_start) begin
        tx_sr    <= WDATA;
        nSS      <= SSEL;
        MOSI     <= WDATA[7];
        bitcnt   <= 3'd0;
        hcnt     <= 3'd0;
        OVR      <= 1'b0;
        BUSY     <= 1'b1;
        rel_pend <= 1'b0;   // a RELEASE in the same cycle loses to WR
        case (DIV)
          2'd0:    half_max <= 3'd0;
          2'd1:    half_max <= 3'd1;
          2'd2:    half_max <= 3'd3;
          default: half_max <= 3'd7;
        endcase
      end else if (state_q == IDLE && RELEASE) begin
        nSS <= 2'b11;
      end

      if (state_q != IDLE) begin
        hcnt <= tick ? 3'd0 : hcnt + 3'd1;
        if (WR) begin
          OVR <= 1'b1;
        end
        if (RELEASE) begin
          rel_pend <= 1'b1;
        end
      end

      if (do_rise) begin
        SCK   <= 1'b1;
        rx_sr <= {rx_sr[6:0], miso_sel};
      end

      if (do_fall) begin
        SCK    <= 1'b0;
        bitcnt <= bitcnt + 3'd1;
        MOSI   <= tx_sr[6];
        tx_sr  <= {tx_sr[6:0], 1'b0};
      end

      if (do_finish) begin
        SCK      <= 1'b0;
        RDATA    <= rx_sr;
        DONE     <= 1'b1;
        BUSY     <= 1'b0;
        rel_pend <= 1'b0;
        // A release that arrived mid-transfer (or on this very edge) lands
        // together with DONE so the slave sees a complete byte first.
        if (rel_pend || RELEASE) begin
          nSS <= 2'b11;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_engine.sv
// tb/tb_spi_engine.sv - directed self-checking bench for spi_engine

module tb_spi_engine;

  logic       CLKx4 = 1'b0;
  logic       nRESET = 1'b0;
  logic       WR = 1'b0;
  logic [7:0] WDATA = 8'h00;
  logic [1:0] SSEL = 2'b11;
  logic [1:0] DIV = 2'd0;
  logic       RELEASE = 1'b0;
  logic [2:0] MISO = 3'b000;
  logic       SCK;
  logic       MOSI;
  logic [1:0] nSS;
  logic [7:0] RDATA;
  logic       BUSY;
  logic       DONE;
  logic       OVR;

  int tests_run = 0;
  int tests_failed = 0;

  spi_engine dut (
    .CLKx4   (CLKx4),
    .nRESET  (nRESET),
    .WR      (WR),
    .WDATA   (WDATA),
    .SSEL    (SSEL),
    .DIV     (DIV),
    .RELEASE (RELEASE),
    .MISO    (MISO),
    .SCK     (SCK),
    .MOSI    (MOSI),
    .nSS     (nSS),
    .RDATA   (RDATA),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .OVR     (OVR)
  );

  always #5 CLKx4 = ~CLKx4;

  // Presents WR for one cycle; returns 1 time unit after the sampling edge
  // (edge 0). The sampled inputs are then scrambled to show they are ignored.
  task automatic start_wr(input logic [7:0] d, input logic [1:0] s, input logic [1:0] dv);
    @(negedge CLKx4);
    WDATA = d;
    SSEL  = s;
    DIV   = dv;
    WR    = 1'b1;
    @(posedge CLKx4);
    #1;
    WR    = 1'b0;
    WDATA = ~d;
    SSEL  = ~s;
    DIV   = ~dv;
  endtask

  task automatic test_reset;
    nRESET = 1'b0;
    repeat (2) @(posedge CLKx4);
    #1;
    tests_run++; if (SCK !== 1'b0) begin tests_failed++; $display("FAIL reset_sck got %b exp 0", SCK); end
    tests_run++; if (MOSI !== 1'b0) begin tests_failed++; $display("FAIL reset_mosi got %b exp 0", MOSI); end
    tests_run++; if (nSS !== 2'b11) begin tests_failed++; $display("FAIL reset_nss got %b exp 11", nSS); end
    tests_run++; if (RDATA !== 8'h00) begin tests_failed++; $display("FAIL reset_rdata got %h exp 00", RDATA); end
    tests_run++; if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b exp 0", BUSY); end
    tests_run++; if (DONE !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b exp 0", DONE); end
    tests_run++; if (OVR !== 1'b0) begin tests_failed++; $display("FAIL reset_ovr got %b exp 0", OVR); end
    @(negedge CLKx4);
    nRESET = 1'b1;
  endtask

  task automatic test_basic;
    logic [7:0] txb = 8'hA5;
    logic [7:0] rxb = 8'h3C;
    int pulses = 0;
    logic prev_sck = 1'b0;
    MISO = {2'b00, rxb[7]};
    start_wr(txb, 2'b10, 2'd0);
    tests_run++; if (BUSY !== 1'b1) begin tests_failed++; $display("FAIL basic_busy0 got %b exp 1", BUSY); end
    tests_run++; if (nSS !== 2'b10) begin tests_failed++; $display("FAIL basic_nss0 got %b exp 10", nSS); end
    tests_run++; if (MOSI !== 1'b1) begin tests_failed++; $display("FAIL basic_mosi0 got %b exp 1", MOSI); end
    tests_run++; if (SCK !== 1'b0) begin tests_failed++; $display("FAIL basic_sck0 got %b exp 0", SCK); end
    for (int e = 0; e < 16; e++) begin
      MISO = {2'b00, rxb[7 - e / 2]};
      @(posedge CLKx4);
      #1;
      if (SCK === 1'b1 && prev_sck === 1'b0) pulses++;
      prev_sck = SCK;
      tests_run++; if (SCK !== ((e + 1) % 2 == 1)) begin tests_failed++; $display("FAIL basic_sck edge %0d got %b", e + 1, SCK); end
      tests_run++; if (DONE !== (e + 1 == 16)) begin tests_failed++; $display("FAIL basic_done edge %0d got %b", e + 1, DONE); end
      tests_run++; if (BUSY !== (e + 1 < 16)) begin tests_failed++; $display("FAIL basic_busy edge %0d got %b", e + 1, BUSY); end
      tests_run++; if (nSS !== 2'b10) begin tests_failed++; $display("FAIL basic_nss edge %0d got %b exp 10", e + 1, nSS); end
      if ((e + 1) % 2 == 1) begin
        tests_run++; if (MOSI !== txb[7 - (e + 1) / 2]) begin tests_failed++; $display("FAIL basic_mosi edge %0d got %b exp %b", e + 1, MOSI, txb[7 - (e + 1) / 2]); end
      end
    end
    tests_run++; if (pulses != 8) begin tests_failed++; $display("FAIL basic_pulses got %0d exp 8", pulses); end
    tests_run++; if (RDATA !== 8'h3C) begin tests_failed++; $display("FAIL basic_rdata got %h exp 3c", RDATA); end
  endtask

  task automatic test_slow;
    logic [7:0] txb = 8'h5A;
    MISO = 3'b100;
    start_wr(txb, 2'b11, 2'd3);
    for (int ee = 1; ee <= 128; ee++) begin
      @(posedge CLKx4);
      #1;
      tests_run++; if (SCK !== ((ee / 8) % 2 == 1)) begin tests_failed++; $display("FAIL slow_sck edge %0d got %b", ee, SCK); end
      tests_run++; if (DONE !== (ee == 128)) begin tests_failed++; $display("FAIL slow_done edge %0d got %b", ee, DONE); end
      if (ee < 128) begin
        tests_run++; if (MOSI !== txb[7 - ee / 16]) begin tests_failed++; $display("FAIL slow_mosi edge %0d got %b exp %b", ee, MOSI, txb[7 - ee / 16]); end
      end
    end
    tests_run++; if (RDATA !== 8'hFF) begin tests_failed++; $display("FAIL slow_rdata got %h exp ff", RDATA); end
    tests_run++; if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL slow_busy_end got %b exp 0", BUSY); end
  endtask

  task automatic test_overrun;
    logic [7:0] txb = 8'hC3;
    MISO = 3'b010;
    start_wr(txb, 2'b01, 2'd0);
    for (int ee = 1; ee <= 16; ee++) begin
      if (ee == 5) begin
        WR = 1'b1; WDATA = 8'h00; SSEL = 2'b10; DIV = 2'd3;
      end
      @(posedge CLKx4);
      #1;
      WR = 1'b0;
      tests_run++; if (SCK !== (ee % 2 == 1)) begin tests_failed++; $display("FAIL ovr_sck edge %0d got %b", ee, SCK); end
      tests_run++; if (DONE !== (ee == 16)) begin tests_failed++; $display("FAIL ovr_done edge %0d got %b", ee, DONE); end
      tests_run++; if (nSS !== 2'b01) begin tests_failed++; $display("FAIL ovr_nss edge %0d got %b exp 01", ee, nSS); end
      tests_run++; if (OVR !== (ee >= 5)) begin tests_failed++; $display("FAIL ovr_flag edge %0d got %b", ee, OVR); end
      if (ee % 2 == 1) begin
        tests_run++; if (MOSI !== txb[7 - ee / 2]) begin tests_failed++; $display("FAIL ovr_mosi edge %0d got %b exp %b", ee, MOSI, txb[7 - ee / 2]); end
      end
    end
    tests_run++; if (RDATA !== 8'hFF) begin tests_failed++; $display("FAIL ovr_rdata got %h exp ff", RDATA); end
    start_wr(8'h0F, 2'b01, 2'd0);
    tests_run++; if (OVR !== 1'b0) begin tests_failed++; $display("FAIL ovr_clear got %b exp 0", OVR); end
    tests_run++; if (BUSY !== 1'b1) begin tests_failed++; $display("FAIL ovr_restart_busy got %b exp 1", BUSY); end
    repeat (16) @(posedge CLKx4);
    #1;
    tests_run++; if (DONE !== 1'b1) begin tests_failed++; $display("FAIL ovr_second_done got %b exp 1", DONE); end
  endtask

  task automatic test_release;
    MISO = 3'b000;
    start_wr(8'h96, 2'b10, 2'd0);
    for (int ee = 1; ee <= 16; ee++) begin
      if (ee == 4) RELEASE = 1'b1;
      @(posedge CLKx4);
      #1;
      RELEASE = 1'b0;
      tests_run++; if (nSS !== ((ee == 16) ? 2'b11 : 2'b10)) begin tests_failed++; $display("FAIL rel_busy_nss edge %0d got %b", ee, nSS); end
      if (ee == 16) begin
        tests_run++; if (DONE !== 1'b1) begin tests_failed++; $display("FAIL rel_busy_done got %b exp 1", DONE); end
      end
    end
    start_wr(8'h11, 2'b01, 2'd0);
    repeat (17) @(posedge CLKx4);
    #1;
    tests_run++; if (nSS !== 2'b01) begin tests_failed++; $display("FAIL rel_idle_pre got %b exp 01", nSS); end
    @(negedge CLKx4);
    RELEASE = 1'b1;
    @(posedge CLKx4);
    #1;
    RELEASE = 1'b0;
    tests_run++; if (nSS !== 2'b11) begin tests_failed++; $display("FAIL rel_idle_nss got %b exp 11", nSS); end
    // WR and RELEASE together: WR wins, release is forgotten.
    @(negedge CLKx4);
    WR = 1'b1; RELEASE = 1'b1; WDATA = 8'h44; SSEL = 2'b10; DIV = 2'd0;
    @(posedge CLKx4);
    #1;
    WR = 1'b0; RELEASE = 1'b0;
    tests_run++; if (nSS !== 2'b10) begin tests_failed++; $display("FAIL rel_wr_tie_start got %b exp 10", nSS); end
    repeat (16) @(posedge CLKx4);
    #1;
    tests_run++; if (DONE !== 1'b1) begin tests_failed++; $display("FAIL rel_wr_tie_done got %b exp 1", DONE); end
    tests_run++; if (nSS !== 2'b10) begin tests_failed++; $display("FAIL rel_wr_tie_end got %b exp 10", nSS); end
  endtask

  task automatic test_reset_mid;
    MISO = 3'b010;
    start_wr(8'hA5, 2'b10, 2'd0);
    repeat (7) @(posedge CLKx4);
    #1;
    tests_run++; if (SCK !== 1'b1) begin tests_failed++; $display("FAIL rstmid_pre_sck got %b exp 1", SCK); end
    nRESET = 1'b0;
    #1;
    tests_run++; if (SCK !== 1'b0) begin tests_failed++; $display("FAIL rstmid_sck got %b exp 0", SCK); end
    tests_run++; if (nSS !== 2'b11) begin tests_failed++; $display("FAIL rstmid_nss got %b exp 11", nSS); end
    tests_run++; if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy got %b exp 0", BUSY); end
    tests_run++; if (RDATA !== 8'h00) begin tests_failed++; $display("FAIL rstmid_rdata got %h exp 00", RDATA); end
    for (int i = 0; i < 3; i++) begin
      @(posedge CLKx4);
      #1;
      tests_run++; if (DONE !== 1'b0) begin tests_failed++; $display("FAIL rstmid_done cycle %0d got %b", i, DONE); end
    end
    @(negedge CLKx4);
    nRESET = 1'b1;
    WR = 1'b1; WDATA = 8'h3C; SSEL = 2'b01; DIV = 2'd0;
    @(posedge CLKx4);
    #1;
    WR = 1'b0;
    tests_run++; if (BUSY !== 1'b1) begin tests_failed++; $display("FAIL rstmid_first_wr got %b exp 1", BUSY); end
    for (int ee = 1; ee <= 16; ee++) begin
      @(posedge CLKx4);
      #1;
      tests_run++; if (DONE !== (ee == 16)) begin tests_failed++; $display("FAIL rstmid_done2 edge %0d got %b", ee, DONE); end
      tests_run++; if (BUSY !== (ee < 16)) begin tests_failed++; $display("FAIL rstmid_busy2 edge %0d got %b", ee, BUSY); end
    end
    tests_run++; if (RDATA !== 8'hFF) begin tests_failed++; $display("FAIL rstmid_rdata2 got %h exp ff", RDATA); end
  endtask

  task automatic test_back_to_back;
    MISO = 3'b000;
    start_wr(8'h81, 2'b01, 2'd0);
    for (int ee = 1; ee <= 16; ee++) begin
      @(posedge CLKx4);
      #1;
      tests_run++; if (nSS !== 2'b01) begin tests_failed++; $display("FAIL b2b_nss1 edge %0d got %b exp 01", ee, nSS); end
      tests_run++; if (DONE !== (ee == 16)) begin tests_failed++; $display("FAIL b2b_done1 edge %0d got %b", ee, DONE); end
    end
    start_wr(8'h7E, 2'b01, 2'd0);
    tests_run++; if (BUSY !== 1'b1) begin tests_failed++; $display("FAIL b2b_busy2 got %b exp 1", BUSY); end
    tests_run++; if (nSS !== 2'b01) begin tests_failed++; $display("FAIL b2b_nss_gap got %b exp 01", nSS); end
    tests_run++; if (MOSI !== 1'b0) begin tests_failed++; $display("FAIL b2b_mosi2 got %b exp 0", MOSI); end
    for (int ee = 1; ee <= 16; ee++) begin
      @(posedge CLKx4);
      #1;
      tests_run++; if (nSS !== 2'b01) begin tests_failed++; $display("FAIL b2b_nss2 edge %0d got %b exp 01", ee, nSS); end
      tests_run++; if (DONE !== (ee == 16)) begin tests_failed++; $display("FAIL b2b_done2 edge %0d got %b", ee, DONE); end
    end
    tests_run++; if (RDATA !== 8'h00) begin tests_failed++; $display("FAIL b2b_rdata got %h exp 00", RDATA); end
  endtask

  task automatic test_done_edge_wr;
    MISO = 3'b000;
    start_wr(8'hFF, 2'b01, 2'd0);
    for (int ee = 1; ee <= 16; ee++) begin
      if (ee == 16) begin
        WR = 1'b1; WDATA = 8'h12; SSEL = 2'b01; DIV = 2'd0;
      end
      @(posedge CLKx4);
      #1;
      WR = 1'b0;
    end
    tests_run++; if (DONE !== 1'b1) begin tests_failed++; $display("FAIL doneedge_done got %b exp 1", DONE); end
    @(posedge CLKx4);
    #1;
    tests_run++; if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL doneedge_busy got %b exp 0", BUSY); end
    tests_run++; if (OVR !== 1'b1) begin tests_failed++; $display("FAIL doneedge_ovr got %b exp 1", OVR); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_slow();
    test_overrun();
    test_release();
    test_reset_mid();
    test_back_to_back();
    test_done_edge_wr();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
